// File: rtl/xsyncfilter_if.sv
// xsyncfilter_if: synchronized input bus, sticky-flag clears and filtered outputs of xsyncfilter.
interface xsyncfilter_if #(parameter int BWID = 1);
  logic [BWID-1:0] x, clr, y, rise, fall, chg;
  logic any_chg;
  modport master(output x, clr, input y, rise, fall, chg, any_chg);
  modport slave(input x, clr, output y, rise, fall, chg, any_chg);
endinterface

// File: rtl/xsyncfilter.sv
// xsyncfilter: per-bit stability filter with rise/fall pulses and sticky change flags.
module xsyncfilter #(
  parameter int BWID = 1,
  parameter int NSTABLE = 4,
  parameter logic [BWID-1:0] INIT = '0
) (
  input logic dclk,
  input logic drst_n,
  xsyncfilter_if.slave bus
);
  localparam int CW = NSTABLE > 1 ? $clog2(NSTABLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSTABLE - 1);
  logic [BWID-1:0] y, rise, fall, chg, acc;
  logic [CW-1:0] cnt [BWID];
  always_comb begin
    acc = '0;
    for (int i = 0; i < BWID; i++) acc[i] = (bus.x[i] != y[i]) && (cnt[i] == LAST);
  end
  // a counter restarts whenever the input agrees with y or a change is accepted
  always_ff @(posedge dclk or negedge drst_n)
    if (!drst_n) begin
      y <= INIT;
      rise <= '0;
      fall <= '0;
      chg <= '0;
      for (int i = 0; i < BWID; i++) cnt[i] <= '0;
    end else begin
      y <= y ^ acc;
      rise <= acc & bus.x;
      fall <= acc & ~bus.x;
      chg <= (chg & ~bus.clr) | acc;
      for (int i = 0; i < BWID; i++) cnt[i] <= (bus.x[i] == y[i] || acc[i]) ? '0 : cnt[i] + 1'b1;
    end
  assign bus.y = y;
  assign bus.rise = rise;
  assign bus.fall = fall;
  assign bus.chg = chg;
  assign bus.any_chg = |chg;
endmodule

// File: tb/tb_xsyncfilter.sv
// tb_xsyncfilter: directed and random checks of xsyncfilter against a sliding-window model.
module tb_xsyncfilter;
  logic dclk = 0, rst_n = 0;
  int pass = 0, total = 0;
  xsyncfilter_if #(.BWID(4)) b4();
  xsyncfilter_if #(.BWID(8)) b8();
  xsyncfilter #(.BWID(4), .NSTABLE(4), .INIT(4'b0101)) u4(.dclk(dclk), .drst_n(rst_n), .bus(b4));
  xsyncfilter #(.BWID(8), .NSTABLE(1), .INIT(8'h00)) u1(.dclk(dclk), .drst_n(rst_n), .bus(b8));
  always #5 dclk = ~dclk;

  // model: a bit is accepted once the last NSTABLE samples since reset all differ from y
  logic [3:0] h4[$];
  logic [7:0] h1[$];
  logic [3:0] my4, mr4, mf4, mc4, a4;
  logic [7:0] my1, mr1, mf1, mc1, a1;
  always @(posedge dclk or negedge rst_n)
    if (!rst_n) begin
      h4.delete(); h1.delete();
      my4 = 4'b0101; mr4 = 0; mf4 = 0; mc4 = 0;
      my1 = 0; mr1 = 0; mf1 = 0; mc1 = 0;
    end else begin
      h4.push_back(b4.x); if (h4.size() > 4) void'(h4.pop_front());
      h1.push_back(b8.x); if (h1.size() > 1) void'(h1.pop_front());
      a4 = 0; a1 = 0;
      for (int i = 0; i < 4; i++) if (h4.size() == 4) begin
        a4[i] = 1;
        foreach (h4[k]) if (h4[k][i] == my4[i]) a4[i] = 0;
      end
      for (int i = 0; i < 8; i++) begin
        a1[i] = 1;
        foreach (h1[k]) if (h1[k][i] == my1[i]) a1[i] = 0;
      end
      mr4 = a4 & b4.x; mf4 = a4 & ~b4.x; mc4 = (mc4 & ~b4.clr) | a4; my4 = my4 ^ a4;
      mr1 = a1 & b8.x; mf1 = a1 & ~b8.x; mc1 = (mc1 & ~b8.clr) | a1; my1 = my1 ^ a1;
    end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge dclk) begin
    #1;
    chk("y4", 32'(b4.y), 32'(my4));
    chk("rise4", 32'(b4.rise), 32'(mr4));
    chk("fall4", 32'(b4.fall), 32'(mf4));
    chk("chg4", 32'(b4.chg), 32'(mc4));
    chk("any4", 32'(b4.any_chg), 32'(|mc4));
    chk("y1", 32'(b8.y), 32'(my1));
    chk("rise1", 32'(b8.rise), 32'(mr1));
    chk("fall1", 32'(b8.fall), 32'(mf1));
    chk("chg1", 32'(b8.chg), 32'(mc1));
    chk("any1", 32'(b8.any_chg), 32'(|mc1));
  end

  task automatic step(int n);
    repeat (n) @(negedge dclk);
  endtask

  initial begin
    logic [3:0] bounce [8];
    bounce = '{4'hE, 4'hE, 4'hE, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE};
    b4.x = 4'hF; b4.clr = 0; b8.x = 0; b8.clr = 0;
    step(3);
    chk("rst_y4", 32'(b4.y), 32'h5);
    chk("rst_pulse4", 32'({b4.rise, b4.fall, b4.chg, 3'b0, b4.any_chg}), 32'h0);
    rst_n = 1;
    step(3); chk("pre_y4", 32'(b4.y), 32'h5);
    step(1); chk("rel_y4", 32'(b4.y), 32'hF); chk("rel_rise4", 32'(b4.rise), 32'hA);
    step(1); chk("rel_rise_end", 32'(b4.rise), 32'h0); chk("rel_chg4", 32'(b4.chg), 32'hA);
    b4.clr = 4'hF; step(1); chk("clr_chg4", 32'(b4.chg), 32'h0); b4.clr = 0;
    b4.x = 4'hE; step(3); b4.x = 4'hF; step(2);
    chk("glitch_y4", 32'(b4.y), 32'hF); chk("glitch_chg4", 32'(b4.chg), 32'h0);
    b4.x = 4'hE; step(3); chk("thr_y4_early", 32'(b4.y), 32'hF);
    step(1); chk("thr_y4", 32'(b4.y), 32'hE); chk("thr_fall4", 32'(b4.fall), 32'h1);
    step(1); chk("thr_fall_end", 32'(b4.fall), 32'h0);
    b4.x = 4'hF; step(4); chk("thr_rise4", 32'(b4.rise), 32'h1); chk("thr_y4b", 32'(b4.y), 32'hF);
    b4.clr = 4'hF; step(1); b4.clr = 0;
    for (int i = 0; i < 8; i++) begin
      b4.x = bounce[i]; step(1);
      if (i == 6) chk("bounce_y4_early", 32'(b4.y), 32'hF);
    end
    chk("bounce_y4", 32'(b4.y), 32'hE);
    b4.clr = 4'b0100; b4.x = 4'hA; step(4);
    chk("coll_y4", 32'(b4.y), 32'hA); chk("coll_chg2", 32'(b4.chg[2]), 32'h1);
    step(1); chk("coll_clr2", 32'(b4.chg[2]), 32'h0);
    b4.clr = 4'hF; step(1); chk("coll_any", 32'(b4.any_chg), 32'h0); b4.clr = 0;
    b8.x = 8'hA5; step(1); chk("pt_y1", 32'(b8.y), 32'hA5); chk("pt_rise1", 32'(b8.rise), 32'hA5);
    b8.x = 8'h5A; step(1); chk("pt_y1b", 32'(b8.y), 32'h5A);
    chk("pt_rise1b", 32'(b8.rise), 32'h5A); chk("pt_fall1b", 32'(b8.fall), 32'hA5);
    step(1); chk("pt_rise_end", 32'(b8.rise), 32'h0);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 5) == 0) b4.x[i] = ~b4.x[i];
      b4.clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      b8.x = ($urandom_range(0, 1) == 0) ? 8'($urandom) : b8.x;
      b8.clr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
      if (c == 200) begin
        rst_n = 0; step(1);
        chk("midrst_y4", 32'(b4.y), 32'h5); chk("midrst_chg1", 32'(b8.chg), 32'h0);
        rst_n = 1;
      end
      step(1);
    end
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/xsyncfilter.md
# xsyncfilter

Per-bit glitch filter and edge detector that sits directly downstream of the multi-stage synchronizer, in the destination clock domain. It takes the already-synchronized bus and accepts a new level on a bit only after that level has been stable for NSTABLE consecutive cycles. For every accepted change it produces a one-cycle rise/fall pulse and sets a sticky change flag that software or a controller clears. It has no CDC logic of its own: its input must already be synchronous to `dclk`.

## Interface
- `BWID`, 1: bus width, number of independent filtered bits.
- `NSTABLE`, 4: consecutive differing cycles required before a bit's filtered level updates; legal range 1..65535.
- `INIT`, {BWID{1'b0}}: reset value of the filtered level `y`.
- `dclk`  in  1  destination clock; all logic is clocked on its rising edge.
- `drst_n`  in  1  asynchronous, active-low reset; deassertion is synchronous to `dclk` outside this block.
- `x`  in  BWID  synchronized input bus (synchronizer output).
- `clr`  in  BWID  per-bit clear of the sticky flag `chg`.
- `y`  out  BWID  filtered level.
- `rise`  out  BWID  one-cycle pulse on an accepted 0->1 change of `y`.
- `fall`  out  BWID  one-cycle pulse on an accepted 1->0 change of `y`.
- `chg`  out  BWID  sticky flag, set on any accepted change.
- `any_chg`  out  1  OR-reduction of `chg` (combinational from `chg` flops).

## Operation
- Each bit i has a private counter `cnt[i]` of width max(1, clog2(NSTABLE)).
- Per rising edge, for each bit i:
  - If x[i] == y[i]: cnt[i] <= 0.
  - If x[i] != y[i] and cnt[i] == NSTABLE-1: y[i] <= x[i], cnt[i] <= 0. rise[i] or fall[i] <= 1 according to the new value.
  - If x[i] != y[i] and cnt[i] != NSTABLE-1: cnt[i] <= cnt[i]+1.
- Any cycle in which x[i] equals y[i] restarts qualification. A glitch shorter than NSTABLE cycles therefore never reaches `y`.
- `rise` and `fall` are registered and deasserted every cycle in which no change is accepted. rise[i] and fall[i] are never both 1.
- chg[i] <= (chg[i] & ~clr[i]) | accepted_change[i]. If a set and a clear hit the same cycle, the set wins so no event is lost.
- NSTABLE == 1: `y` is a plain one-cycle registered copy of `x`. Pulses still fire on every change.
- Bits are fully independent. There is no cross-bit interaction except `any_chg`.

## Timing
- Reset (drst_n = 0, asynchronous): y = INIT, cnt = 0, rise = 0, fall = 0, chg = 0, any_chg = 0.
- Latency: x[i] flips before edge k and holds. y[i], together with its rise/fall pulse, updates after edge k+NSTABLE-1, i.e. NSTABLE edges after the input change.
- Pulse width: exactly one `dclk` cycle. It is coincident with the first cycle the new `y` is visible.
- chg[i] rises in the same cycle as the pulse. It clears one edge after `clr[i]` is sampled high, unless a change is accepted on that edge.
- Reset asserted mid-qualification discards the partial count. After release, `y` = INIT. If x differs from INIT, a full NSTABLE qualification must elapse and then a pulse fires.
- Counter never exceeds NSTABLE-1. It does not wrap.

## Test plan
- Reset/defaults: BWID=4, INIT=4'b0101, hold drst_n=0 with x=4'b1111. Required: y=4'b0101, rise=fall=chg=0. After release, with NSTABLE=4, y=4'b1111 four edges later, with rise=4'b1010 pulsed for one cycle.
- Glitch reject: NSTABLE=4, y=0. Drive x[0]=1 for 3 cycles, then 0. Required: y[0] stays 0, no pulse, chg[0]=0.
- Exact threshold: NSTABLE=4. Drive x[0]=1 held. Required: y[0]=1 after the 4th edge, rise[0]=1 for exactly one cycle. Then x[0]=0 held gives fall[0] 4 edges later.
- Restart on bounce: NSTABLE=4. Drive x[0] as 1,1,1,0,1,1,1,1. Required: y[0] updates only after the 4th consecutive 1, i.e. 8 edges after the first 1.
- Sticky flag set/clear collision: accept a change on bit 2 while clr[2]=1 on the same edge. Required: chg[2]=1 afterwards. clr[2]=1 on the next idle edge gives chg[2]=0 and any_chg=0.
- NSTABLE=1 pass-through: BWID=8. Drive x through 8'h00->8'hA5->8'h5A on consecutive cycles. Required: y follows one edge later. rise=8'hA5, then 8'h5A, with fall=8'hA5 on the second change.
